// File: rtl/ecg_sign_bits_packer.sv
// ecg_sign_bits_packer: extracts the sign bits of the non-zero residuals in each
// group, packs them MSB-first across groups into OUT_W-bit words, and drains a
// partial word on flush at the end of a block.
//
// Handshake contract (both sides): a transfer happens on a rising edge where
// valid && ready are both high. A producer holds its payload stable while valid
// is high and ready is low. in_ready is combinational: a word leaving this cycle
// frees the output register, so a new group can be accepted in the same cycle.
module ecg_sign_bits_packer #(
  parameter int J        = 10,
  parameter int N        = 4,
  parameter int NUM_ECG  = 4,
  parameter int SKIP_ECG = 3,
  parameter int OUT_W    = 16,
  localparam int EW      = (NUM_ECG > 1) ? $clog2(NUM_ECG) : 1,
  localparam int SW      = $clog2(N + 1),
  localparam int BW      = $clog2(OUT_W + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*J-1:0] samples,
  input  logic [EW-1:0]  ecgidx,
  input  logic           group_skip_flag,
  input  logic           flush,
  output logic           grp_valid,
  output logic [N-1:0]   sign_bits,
  output logic [SW-1:0]  size_sign_bits,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OUT_W-1:0] out_word,
  output logic [BW-1:0]  out_bits,
  output logic           out_last,
  output logic           dbg_state
);

  // Buffer can hold a not-yet-full word plus one whole group.
  localparam int BUF_W = OUT_W + N - 1;
  localparam int TW    = $clog2(BUF_W + 1);

  typedef enum logic {ACCUM = 1'b0, FLUSH_PEND = 1'b1} state_t;

  state_t           state;
  logic [BUF_W-1:0] buf_q;
  logic [BW-1:0]    cnt_q;

  logic             accept;
  logic             flush_fire;
  logic [N-1:0]     ext_bits;
  logic [SW-1:0]    ext_cnt;
  logic [N-1:0]     grp_bits;
  logic [SW-1:0]    grp_cnt;
  logic [BUF_W-1:0] ext_wide;
  logic [BUF_W-1:0] merged;
  logic [BUF_W-1:0] rest;
  logic [OUT_W-1:0] top;
  logic [TW-1:0]    total;

  assign in_ready   = !(out_valid && !out_ready) && (state == ACCUM);
  assign accept     = in_valid && in_ready;
  assign flush_fire = flush && in_ready;
  assign dbg_state  = (state == FLUSH_PEND);

  // Compact the sign bits of non-zero samples, first contributor at the MSB.
  always_comb begin
    ext_bits = '0;
    ext_cnt  = '0;
    if (!(group_skip_flag || (ecgidx == EW'(SKIP_ECG)))) begin
      for (int k = 0; k < N; k++) begin
        if (samples[k*J +: J] != '0) begin
          ext_bits = ext_bits | (N'(samples[k*J+J-1]) << (SW'(N - 1) - ext_cnt));
          ext_cnt  = ext_cnt + SW'(1);
        end
      end
    end
  end

  // A flush without a group contributes no bits.
  assign grp_bits = accept ? ext_bits : '0;
  assign grp_cnt  = accept ? ext_cnt  : '0;

  // Append the new bits directly behind the cnt_q bits already buffered.
  assign ext_wide = BUF_W'(grp_bits) << (BUF_W - N);
  assign merged   = buf_q | (ext_wide >> cnt_q);
  assign total    = TW'(cnt_q) + TW'(grp_cnt);
  assign top      = merged[BUF_W-1 -: OUT_W];
  assign rest     = merged << OUT_W;

  // Per-group result registers, accumulator, output word register and FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ACCUM;
      buf_q          <= '0;
      cnt_q          <= '0;
      grp_valid      <= 1'b0;
      sign_bits      <= '0;
      size_sign_bits <= '0;
      out_valid      <= 1'b0;
      out_word       <= '0;
      out_bits       <= '0;
      out_last       <= 1'b0;
    end else begin
      grp_valid <= accept;
      if (accept) begin
        sign_bits      <= ext_bits;
        size_sign_bits <= ext_cnt;
      end

      // Drained word; any load below overrides this.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      case (state)
        ACCUM: begin
          if (flush_fire && (total > TW'(OUT_W))) begin
            // Too many bits for one word: send a full one, residue follows.
            out_valid <= 1'b1;
            out_word  <= top;
            out_bits  <= BW'(OUT_W);
            out_last  <= 1'b0;
            buf_q     <= rest;
            cnt_q     <= BW'(total - TW'(OUT_W));
            state     <= FLUSH_PEND;
          end else if (flush_fire) begin
            if (total != '0) begin
              out_valid <= 1'b1;
              out_word  <= top;
              out_bits  <= BW'(total);
              out_last  <= 1'b1;
            end
            buf_q <= '0;
            cnt_q <= '0;
          end else if (accept && (total >= TW'(OUT_W))) begin
            out_valid <= 1'b1;
            out_word  <= top;
            out_bits  <= BW'(OUT_W);
            out_last  <= 1'b0;
            buf_q     <= rest;
            cnt_q     <= BW'(total - TW'(OUT_W));
          end else if (accept) begin
            buf_q <= merged;
            cnt_q <= BW'(total);
          end
        end
        FLUSH_PEND: begin
          // Residue goes out as soon as the full word is taken.
          if (out_valid && out_ready) begin
            out_valid <= 1'b1;
            out_word  <= buf_q[BUF_W-1 -: OUT_W];
            out_bits  <= cnt_q;
            out_last  <= 1'b1;
            buf_q     <= '0;
            cnt_q     <= '0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_ecg_sign_bits_packer.sv
// Bench for ecg_sign_bits_packer: directed scenarios with literal expectations
// followed by randomized traffic, all checked against a bit-queue model.
module tb_ecg_sign_bits_packer;

  localparam int J        = 10;
  localparam int N        = 4;
  localparam int NUM_ECG  = 4;
  localparam int SKIP_ECG = 3;
  localparam int OUT_W    = 16;
  localparam int EW       = 2;
  localparam int SW       = 3;
  localparam int BW       = 5;
  localparam int XW       = 1 + BW + OUT_W;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N*J-1:0]   samples;
  logic [EW-1:0]    ecgidx;
  logic             group_skip_flag;
  logic             flush;
  logic             grp_valid;
  logic [N-1:0]     sign_bits;
  logic [SW-1:0]    size_sign_bits;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_word;
  logic [BW-1:0]    out_bits;
  logic             out_last;
  logic             dbg_state;

  always #5 clk = ~clk;

  ecg_sign_bits_packer #(
    .J(J), .N(N), .NUM_ECG(NUM_ECG), .SKIP_ECG(SKIP_ECG), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .samples(samples), .ecgidx(ecgidx), .group_skip_flag(group_skip_flag),
    .flush(flush),
    .grp_valid(grp_valid), .sign_bits(sign_bits), .size_sign_bits(size_sign_bits),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_bits(out_bits), .out_last(out_last),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_total = 0;
  int n_bad   = 0;

  logic [XW-1:0]   exp_q[$];   // expected words {last, bits, word}
  logic [SW+N-1:0] gq[$];      // expected per-group {size, sign_bits}
  bit              mbits[$];   // bits not yet placed in a word
  logic [N-1:0]    exp_sb;
  logic [SW-1:0]   exp_ss;
  logic [SW+N-1:0] g;
  logic            rdy_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [N*J-1:0] mk(input int a, input int b, input int c, input int d);
    logic [J-1:0] va, vb, vc, vd;
    va = J'(a); vb = J'(b); vc = J'(c); vd = J'(d);
    return {vd, vc, vb, va};
  endfunction

  function automatic logic [N*J-1:0] rnd_samples();
    logic [N*J-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(0, 2) != 0) r[k*J +: J] = J'($urandom_range(0, (1 << J) - 1));
    end
    return r;
  endfunction

  // Take nb bits from the front of the bit queue, left-aligned, zero padded.
  function automatic logic [XW-1:0] make_word(input int nb, input logic last);
    logic [OUT_W-1:0] w;
    w = '0;
    for (int i = 0; i < OUT_W; i++) w = {w[OUT_W-2:0], (i < nb) ? mbits.pop_front() : 1'b0};
    return {last, BW'(nb), w};
  endfunction

  // Model of one accepted cycle: sign bits of negative values, word cutting.
  task automatic model_step(input logic v, input logic fl, input logic [N*J-1:0] smp,
                            input logic [EW-1:0] e, input logic sk);
    logic [N-1:0]          sb;
    int                    s;
    logic signed [J-1:0]   val;
    sb = '0;
    s  = 0;
    if (v) begin
      if (!(sk || e == SKIP_ECG)) begin
        for (int k = 0; k < N; k++) begin
          val = smp[k*J +: J];
          if (val != 0) begin
            sb = {sb[N-2:0], val < 0};
            mbits.push_back(val < 0);
            s++;
          end
        end
      end
      if (s > 0) sb = sb << (N - s);
      gq.push_back({SW'(s), sb});
    end
    if (fl) begin
      if (mbits.size() > OUT_W) exp_q.push_back(make_word(OUT_W, 1'b0));
      if (mbits.size() > 0)     exp_q.push_back(make_word(mbits.size(), 1'b1));
    end else if (mbits.size() >= OUT_W) begin
      exp_q.push_back(make_word(OUT_W, 1'b0));
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      gq.delete();
      mbits.delete();
      exp_sb = '0;
      exp_ss = '0;
    end else begin
      rdy_exp = ((exp_q.size() == 0) || out_ready) && (exp_q.size() < 2);
      if (gq.size() > 0) begin
        g      = gq.pop_front();
        exp_sb = g[N-1:0];
        exp_ss = g[SW+N-1:N];
        chk("grp_valid", grp_valid, 1);
      end else begin
        chk("grp_valid_idle", grp_valid, 0);
      end
      chk("sign_bits", sign_bits, exp_sb);
      chk("size_sign_bits", size_sign_bits, exp_ss);
      chk("out_valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) chk("out_word_bits_last", {out_last, out_bits, out_word}, exp_q[0]);
      chk("in_ready", in_ready, rdy_exp);
      if ((exp_q.size() > 0) && out_ready) void'(exp_q.pop_front());
      if (rdy_exp) model_step(in_valid, flush, samples, ecgidx, group_skip_flag);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [N*J-1:0] smp, input int e, input logic sk,
                      input logic v, input logic fl);
    bit ok;
    samples = smp; ecgidx = EW'(e); group_skip_flag = sk; in_valid = v; flush = fl;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_total++;
      n_bad++;
      $display("FAIL accept_timeout: actual=in_ready low required=accept within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; samples = '0; ecgidx = '0;
    group_skip_flag = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_grp_valid", grp_valid, 0);
    idle(1);

    // 1: two contributors, one negative
    send(mk(-3, 0, 5, 0), 0, 0, 1, 0);
    chk("t1_grp_valid", grp_valid, 1);
    chk("t1_sign_bits", sign_bits, 4'b1000);
    chk("t1_size", size_sign_bits, 2);
    chk("t1_no_word", out_valid, 0);

    // 2: skipped index and skip flag contribute nothing; count stays 2
    send(mk(-1, -2, -3, -4), 3, 0, 1, 0);
    chk("t2_skip_idx_size", size_sign_bits, 0);
    chk("t2_skip_idx_bits", sign_bits, 0);
    send(mk(-1, -2, -3, -4), 0, 1, 1, 0);
    chk("t2_skip_flag_size", size_sign_bits, 0);
    chk("t2_skip_flag_grp_valid", grp_valid, 1);
    send('0, 0, 0, 0, 1);
    chk("t2_flush_word", out_word, 16'h8000);
    chk("t2_flush_bits", out_bits, 2);
    chk("t2_flush_last", out_last, 1);
    idle(1);
    chk("t2_drained", out_valid, 0);

    // 3: sixteen ones make one full word
    for (int i = 0; i < 4; i++) send(mk(-1, -1, -1, -1), 0, 0, 1, 0);
    chk("t3_valid", out_valid, 1);
    chk("t3_word", out_word, 16'hFFFF);
    chk("t3_bits", out_bits, 16);
    chk("t3_last", out_last, 0);
    send('0, 0, 0, 0, 1);
    chk("t3_empty_flush_valid", out_valid, 0);
    chk("t3_empty_flush_last", out_last, 0);

    // 4: crossing a word boundary, then residue flush
    for (int i = 0; i < 3; i++) send(mk(-7, -8, -9, -10), 1, 0, 1, 0);
    send(mk(-1, -1, -1, 0), 2, 0, 1, 0);
    send(mk(1, 2, 3, 4), 0, 0, 1, 0);
    chk("t4_word", out_word, 16'hFFFE);
    chk("t4_bits", out_bits, 16);
    send('0, 0, 0, 0, 1);
    chk("t4_flush_word", out_word, 16'h0000);
    chk("t4_flush_bits", out_bits, 3);
    chk("t4_flush_last", out_last, 1);
    idle(1);

    // 5: backpressure holds the word and blocks input
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(mk(-1, -1, -1, -1), 0, 0, 1, 0);
    repeat (5) begin
      @(negedge clk);
      chk("t5_in_ready_low", in_ready, 0);
      chk("t5_word_stable", out_word, 16'hFFFF);
      chk("t5_valid_held", out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(mk(-1, -1, -1, -1), 0, 0, 1, 0);
    chk("t5_same_cycle_accept", grp_valid, 1);
    chk("t5_word_consumed", out_valid, 0);
    send('0, 0, 0, 0, 1);
    chk("t5_flush_word", out_word, 16'hF000);
    chk("t5_flush_bits", out_bits, 4);
    idle(1);

    // 6a: flush overflowing one word
    for (int i = 0; i < 3; i++) send(mk(-1, -1, -1, -1), 0, 0, 1, 0);
    send(mk(-1, -1, 0, 0), 0, 0, 1, 0);
    out_ready = 1'b0;
    send(mk(-1, -1, -1, -1), 0, 0, 1, 1);
    chk("t6_full_word", out_word, 16'hFFFF);
    chk("t6_full_last", out_last, 0);
    chk("t6_pend_in_ready", in_ready, 0);
    out_ready = 1'b1;
    idle(1);
    chk("t6_res_valid", out_valid, 1);
    chk("t6_res_word", out_word, 16'hC000);
    chk("t6_res_bits", out_bits, 2);
    chk("t6_res_last", out_last, 1);
    idle(1);
    chk("t6_res_drained", out_valid, 0);

    // 6b: reset mid-block discards buffered bits
    send(mk(-1, -1, -1, -1), 0, 0, 1, 0);
    send(mk(-1, -1, -1, 0), 0, 0, 1, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t6_rst_grp_valid", grp_valid, 0);
    chk("t6_rst_sign_bits", sign_bits, 0);
    chk("t6_rst_size", size_sign_bits, 0);
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_out_word", out_word, 0);
    chk("t6_rst_out_bits", out_bits, 0);
    chk("t6_rst_out_last", out_last, 0);
    chk("t6_rst_in_ready", in_ready, 1);
    send('0, 0, 0, 0, 1);
    chk("t6_rst_flush_valid", out_valid, 0);
    chk("t6_rst_flush_last", out_last, 0);

    // Randomized traffic, checked by the compare process
    for (int cyc = 0; cyc < 2500; cyc++) begin
      in_valid        = ($urandom_range(0, 3) != 0);
      samples         = rnd_samples();
      ecgidx          = EW'($urandom_range(0, NUM_ECG - 1));
      group_skip_flag = ($urandom_range(0, 7) == 0);
      flush           = ($urandom_range(0, 9) == 0);
      out_ready       = ($urandom_range(0, 3) != 0);
      rst             = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle(3);
    send('0, 0, 0, 0, 1);
    idle(4);
    chk("end_words_left", exp_q.size(), 0);
    chk("end_groups_left", gq.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ecg_sign_bits_packer.md
Name: ecg_sign_bits_packer

Overview:
- Sequential, parametrised successor to the combinational per-group sign-bit extractor in the BP-mode entropy encoder.
- Accepts one group of N residual samples per handshake and extracts the sign bits of the non-zero samples, compacted MSB-first.
- Packs those bits contiguously across successive groups into OUT_W-bit words.
- Presents the words on a valid/ready output to the bitstream assembler; a flush drains any partial word at end of block.

Parameters:
J, 10, sample width (two's complement)
N, 4, samples per group (N >= 1)
NUM_ECG, 4, entropy-coding groups per block (ecgidx range)
SKIP_ECG, 3, ecgidx value whose group carries no sign bits
OUT_W, 16, packed output word width (OUT_W >= N)

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous active-high reset
in_valid  input  1  group presented
in_ready  output  1  group can be accepted
samples  input  N*J  sample k at bits [k*J+J-1 : k*J], k=0 is first
ecgidx  input  clog2(NUM_ECG)  group index
group_skip_flag  input  1  all samples of group are zero
flush  input  1  end of block; qualified by in_ready, may accompany in_valid or stand alone
grp_valid  output  1  one-cycle pulse: registered per-group result valid
sign_bits  output  N  compacted sign bits of last accepted group, left-aligned
size_sign_bits  output  clog2(N+1)  number of valid sign_bits
out_valid  output  1  packed word available
out_ready  input  1  consumer accepts word
out_word  output  OUT_W  packed bits, first bit at MSB
out_bits  output  clog2(OUT_W+1)  valid bits in out_word (OUT_W except on flush word)
out_last  output  1  word is the final (flush) word of block

Behaviour:
- Reset: all outputs 0 except in_ready = 1; accumulator cleared, count = 0, state ACCUM.
- Accept: group taken when in_valid && in_ready.
- Extraction for an accepted group:
  - If ecgidx == SKIP_ECG or group_skip_flag = 1: s = 0, no bits.
  - Otherwise each sample k in order 0..N-1 with value != 0 contributes its bit J-1; s = number of such samples.
  - sign_bits holds these bits left-aligned (first contributor at bit N-1); unused LSBs are 0.
- Per-group registers: sign_bits, size_sign_bits and a grp_valid pulse appear the cycle after acceptance and hold until the next acceptance.
- Accumulator: buffer of OUT_W+N-1 bits plus count c. New bits are appended directly after the existing c bits.
  - If c + s >= OUT_W, the first OUT_W bits are loaded into out_word with out_bits = OUT_W and out_valid = 1 on the next cycle. The remainder c+s-OUT_W is shifted to the front.
  - Otherwise c += s and nothing is emitted.
- Flush (accepted with in_ready = 1), evaluated after appending any simultaneous group:
  - Total t = 0: no word, out_last is not raised.
  - 0 < t <= OUT_W: a single word is emitted, left-aligned, LSBs zero, out_bits = t, out_last = 1. Count returns to 0.
  - t > OUT_W: a full word is emitted (out_last = 0) and the state moves to FLUSH_PEND, with in_ready = 0. When that word is taken, the residue word is emitted with out_last = 1, then the state returns to ACCUM.
- Output handshake:
  - out_word, out_bits and out_last are held stable while out_valid && !out_ready.
  - The word is consumed on out_valid && out_ready; out_valid drops next cycle unless a new word is loaded in the same cycle.
- in_ready = !(out_valid && !out_ready) && state == ACCUM.
  - Combinationally, a word draining this cycle permits accepting a new group in the same cycle.
- Latency: 1 cycle from acceptance to grp_valid and to any word it completes. Full throughput is one group per cycle while out_ready = 1.
- rst asserted mid-block discards the buffer, any pending word and FLUSH_PEND; nothing is emitted afterwards.

Test Plan (J=10, N=4, OUT_W=16):
1. samples {-3,0,5,0}, ecgidx 0 -> next cycle grp_valid=1, sign_bits=4'b1000, size_sign_bits=2, no word.
2. samples {-1,-2,-3,-4}, ecgidx 3; then same samples with group_skip_flag=1 -> size_sign_bits=0 both, sign_bits=0, count unchanged.
3. Four groups of {-1,-1,-1,-1}, ecgidx 0 -> after 4th: out_valid=1, out_word=16'hFFFF, out_bits=16, out_last=0, count 0.
4. Groups sizes 4,4,4 (all negative) + {-1,-1,-1,0}, then {1,2,3,4} -> out_word=16'hFFFE; flush next -> out_word=16'h0000, out_bits=3, out_last=1.
5. Backpressure: word pending, out_ready=0 for 5 cycles -> in_ready=0, out_word stable. Raise out_ready with in_valid high -> word consumed and group accepted the same cycle.
6. Flush overflow then reset: c=14, group of 4 negatives + flush -> full word (out_last=0) then 16'hC000/out_bits 2/out_last 1. Separately, c=7 then rst -> all outputs 0, subsequent flush emits nothing.
